// File: rtl/addsub_pipe_unit.sv
// addsub_pipe_unit: pipelined add/sub with carry/overflow flags, tag passthrough and valid/ready flow control.
// Optional: ADDSUB_SAT_EN saturates the result on overflow (flags still report the raw event).
module addsub_pipe_unit #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int SIGNED  = 0,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       inflight
);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [LATENCY-1:0] v_q, v_d, c_q, c_d, o_q, o_d;
  logic [WIDTH-1:0]   s_q [LATENCY];
  logic [WIDTH-1:0]   s_d [LATENCY];
  logic [TAG_W-1:0]   t_q [LATENCY];
  logic [TAG_W-1:0]   t_d [LATENCY];
  logic [WIDTH:0]     raw;
  logic [WIDTH-1:0]   res;
  logic               sovf, ovf, adv;
  assign raw  = in_sub ? {1'b0, in_a} - {1'b0, in_b} : {1'b0, in_a} + {1'b0, in_b};
  // add overflows on equal operand signs, sub on differing signs; either way the result sign leaves A's
  assign sovf = ((in_a[WIDTH-1] ^ in_b[WIDTH-1]) == in_sub) && (raw[WIDTH-1] != in_a[WIDTH-1]);
  assign ovf  = (SIGNED != 0) ? sovf : raw[WIDTH];
`ifdef ADDSUB_SAT_EN
  assign res = !ovf ? raw[WIDTH-1:0] :
               (SIGNED != 0) ? (in_a[WIDTH-1] ? SMIN : SMAX) :
               in_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
`else
  assign res = raw[WIDTH-1:0];
`endif
  assign out_valid = v_q[LATENCY-1];
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv && !flush;
  assign out_s     = s_q[LATENCY-1];
  assign out_carry = c_q[LATENCY-1];
  assign out_ovf   = o_q[LATENCY-1];
  assign out_tag   = t_q[LATENCY-1];
  always_comb begin
    v_d = v_q;
    c_d = c_q;
    o_d = o_q;
    s_d = s_q;
    t_d = t_q;
    if (adv) begin
      v_d[0] = in_valid && in_ready;
      c_d[0] = raw[WIDTH];
      o_d[0] = ovf;
      s_d[0] = res;
      t_d[0] = in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        v_d[i] = v_q[i-1];
        c_d[i] = c_q[i-1];
        o_d[i] = o_q[i-1];
        s_d[i] = s_q[i-1];
        t_d[i] = t_q[i-1];
      end
    end
    if (flush) v_d = '0;
  end
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + {3'b0, v_q[i]};
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= '0;
      c_q <= '0;
      o_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        s_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      o_q <= o_d;
      s_q <= s_d;
      t_q <= t_d;
    end
  end
endmodule

// File: tb/tb_addsub_pipe_unit.sv
// tb_addsub_pipe_unit: directed table vectors on unsigned and signed instances plus stall/flush/reset sequences.
module tb_addsub_pipe_unit;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [15:0] a, b;
    logic        sub;
    logic [3:0]  tag;
    logic [15:0] us;
    logic        uc, uo;
    logic [15:0] ss;
    logic        sc, so;
  } vec_t;
  vec_t vt [8];
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic [3:0] in_tag = '0;
  logic in_ready, out_valid, out_carry, out_ovf, s_in_ready, s_out_valid, s_out_carry, s_out_ovf;
  logic [15:0] out_s, s_out_s;
  logic [3:0] out_tag, s_out_tag, inflight, s_inflight;
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  addsub_pipe_unit #(.WIDTH(16), .LATENCY(2), .SIGNED(0), .TAG_W(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_tag(out_tag), .inflight(inflight));
  addsub_pipe_unit #(.WIDTH(16), .LATENCY(2), .SIGNED(1), .TAG_W(4)) dut_s (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_s(s_out_s), .out_carry(s_out_carry), .out_ovf(s_out_ovf),
    .out_tag(s_out_tag), .inflight(s_inflight));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic run_vec(input int k);
    in_a = vt[k].a; in_b = vt[k].b; in_sub = vt[k].sub; in_tag = vt[k].tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("v_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("v_lat_valid", out_valid, 0);
    chk("v_lat_inflight", inflight, 1);
    @(posedge clk); #1;
    chk("v_out_valid", out_valid, 1);
    chk("v_inflight", inflight, 1);
    chk($sformatf("v%0d_s", k), out_s, vt[k].us);
    chk($sformatf("v%0d_carry", k), out_carry, vt[k].uc);
    chk($sformatf("v%0d_ovf", k), out_ovf, vt[k].uo);
    chk($sformatf("v%0d_tag", k), out_tag, vt[k].tag);
    chk($sformatf("v%0d_sgn_s", k), s_out_s, vt[k].ss);
    chk($sformatf("v%0d_sgn_carry", k), s_out_carry, vt[k].sc);
    chk($sformatf("v%0d_sgn_ovf", k), s_out_ovf, vt[k].so);
    @(posedge clk); #1;
    chk("v_drain", inflight, 0);
  endtask
  initial begin
    int sent, del;
    vt[0] = '{16'h0005, 16'h0003, 1'b1, 4'h1, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    vt[1] = '{16'h0003, 16'h0005, 1'b1, 4'h2, SAT ? 16'h0000 : 16'hFFFE, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 4'h3, 16'h8000, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'hFFFF, 16'h0001, 1'b0, 4'h4, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 4'h5, 16'h7FFF, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1};
    vt[5] = '{16'h1234, 16'h4321, 1'b0, 4'h6, 16'h5555, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 4'h7, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b1, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
    vt[7] = '{16'h0000, 16'h0000, 1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_s", out_s, 0);
    chk("rst_flags", {out_carry, out_ovf}, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) run_vec(k);
    // back-to-back stream, consumer stalls on cycles 3..5
    sent = 0; del = 0;
    for (int cyc = 0; cyc < 40 && del < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = sent < 8;
      in_a = 16'(sent * 256); in_b = 16'(sent); in_sub = 1'b0; in_tag = 4'(sent);
      #1;
      chk("bb_in_ready", in_ready, !(out_valid && !out_ready));
      chk("bb_inflight", inflight, 32'(sent - del));
      if (out_valid && out_ready) begin
        chk("bb_tag", out_tag, 32'(del));
        chk("bb_s", out_s, 32'(del * 257));
        del++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    chk("bb_delivered", del, 8);
    chk("bb_sent", sent, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bb_empty", inflight, 0);
    // flush while stalled with two ops in flight and a new op offered
    in_valid = 1'b1; out_ready = 1'b0; in_tag = 4'hA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fl_pre_inflight", inflight, 2);
    chk("fl_pre_valid", out_valid, 1);
    flush = 1'b1;
    #1 chk("fl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_inflight", inflight, 0);
    chk("fl_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fl_no_out", out_valid, 0);
    end
    // asynchronous reset mid-stream
    in_valid = 1'b1; in_a = 16'h0010; in_b = 16'h0001; in_sub = 1'b0; in_tag = 4'h9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mr_pre_valid", out_valid, 1);
    resetn = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_s", out_s, 0);
    chk("mr_tag", out_tag, 0);
    chk("mr_inflight", inflight, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1 chk("mr_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("mr_no_partial", out_valid, 0);
    run_vec(0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
